// File: rtl/pack_sk_seq_pkg.sv
// Shared definitions for the Dilithium3 sequential secret-key packer.
// Holds the parameter set, the sk word map (base addresses and word
// counts per polynomial class), the FSM state type and two small helpers
// that translate a polynomial index into its place in the sk word map.
package pack_sk_seq_pkg;

  localparam int K            = 6;
  localparam int L            = 5;
  localparam int ETA          = 4;
  localparam int POLY_N       = 256;
  localparam int COEF_W       = 32;
  localparam int POLY_W       = POLY_N * COEF_W;
  localparam int SK_WORDS     = 1008;
  localparam int HDR_WORDS    = 32;
  localparam int ETA_WORDS    = 32;
  localparam int T0_WORDS     = 104;
  localparam int S1_BASE      = 32;
  localparam int S2_BASE      = 192;
  localparam int T0_BASE      = 384;
  localparam int T0_SEL_FIRST = L + K;
  localparam int HDR_BITS     = 1024;
  localparam int ETA_BITS     = POLY_N * 4;
  localparam int T0_BITS      = POLY_N * 13;
  localparam int T0_OFFSET    = 4096;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    REQ,
    PACK,
    EMIT,
    DONE
  } state_t;

  // First sk word address of polynomial 'sel' (s1, then s2, then t0).
  function automatic logic [9:0] poly_base(input logic [4:0] sel);
    int s;
    s = int'(sel);
    if (s < L)                 return 10'(S1_BASE + ETA_WORDS * s);
    else if (s < T0_SEL_FIRST) return 10'(S2_BASE + ETA_WORDS * (s - L));
    else                       return 10'(T0_BASE + T0_WORDS * (s - T0_SEL_FIRST));
  endfunction

  // Number of 32-bit words produced by polynomial 'sel'.
  function automatic logic [6:0] poly_words(input logic [4:0] sel);
    return (sel < 5'(T0_SEL_FIRST)) ? 7'(ETA_WORDS) : 7'(T0_WORDS);
  endfunction

endpackage

// File: rtl/pack_sk_seq_sk_word_emitter.sv
// sk_word_emitter: holds one packed block (header or polynomial) and
// streams it out as 32-bit words on the sk write port.
//   load/load_data   capture a new block and restart the word counter
//   arm/base_in/nwords_in  register the block's base address and length
//   active           the write port is presenting words
//   wr_ready         sink accepts the current word
//   wr_en/wr_addr/wr_data  write port (zero while inactive)
//   last_xfer        the final word of the block transfers this cycle
module sk_word_emitter
  import pack_sk_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [T0_BITS-1:0] load_data,
  input  logic               arm,
  input  logic [9:0]         base_in,
  input  logic [6:0]         nwords_in,
  input  logic               active,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [9:0]         wr_addr,
  output logic [31:0]        wr_data,
  output logic               last_xfer
);

  logic [T0_BITS-1:0] pack_reg;
  logic [6:0]         word_cnt;
  logic [9:0]         base_reg;
  logic [6:0]         nwords_reg;
  logic               xfer;

  assign xfer = active && wr_ready;

  // The pack register shifts down one word per transfer so the current
  // word is always its bottom 32 bits; without a transfer it holds, which
  // keeps addr/data stable through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg   <= '0;
      word_cnt   <= '0;
      base_reg   <= '0;
      nwords_reg <= '0;
    end else begin
      if (load) begin
        pack_reg <= load_data;
        word_cnt <= '0;
      end else if (xfer) begin
        pack_reg <= pack_reg >> 32;
        word_cnt <= word_cnt + 7'd1;
      end
      if (arm) begin
        base_reg   <= base_in;
        nwords_reg <= nwords_in;
      end
    end
  end

  assign wr_en     = active;
  assign wr_addr   = active ? (base_reg + {3'b000, word_cnt}) : '0;
  assign wr_data   = active ? pack_reg[31:0] : '0;
  assign last_xfer = xfer && (word_cnt == nwords_reg - 7'd1);

endmodule

// File: rtl/polyeta_pack.sv
// polyeta_pack: packs 256 coefficients in [-ETA, ETA] as 4-bit fields of
// (ETA - c), coefficient j at bits [4j+3:4j].
//   coeffs     in  256 x 32-bit coefficients, coefficient j at [32j+31:32j]
//   packed_out out 1024-bit packed polynomial
module polyeta_pack
  import pack_sk_seq_pkg::*;
(
  input  logic [POLY_W-1:0]   coeffs,
  output logic [ETA_BITS-1:0] packed_out
);

  // Only the low nibble of ETA - c survives, so the subtraction is done at
  // 4 bits directly.
  always_comb begin
    packed_out = '0;
    for (int j = 0; j < POLY_N; j++) begin
      packed_out[4*j +: 4] = 4'(ETA) - coeffs[COEF_W*j +: 4];
    end
  end

endmodule

// File: rtl/polyt0_pack.sv
// polyt0_pack: packs 256 t0 coefficients in (-2^12, 2^12] as 13-bit
// fields of (2^12 - c), coefficient j at bits [13j+12:13j].
//   coeffs     in  256 x 32-bit coefficients, coefficient j at [32j+31:32j]
//   packed_out out 3328-bit packed polynomial
module polyt0_pack
  import pack_sk_seq_pkg::*;
(
  input  logic [POLY_W-1:0]  coeffs,
  output logic [T0_BITS-1:0] packed_out
);

  always_comb begin
    packed_out = '0;
    for (int j = 0; j < POLY_N; j++) begin
      packed_out[13*j +: 13] = 13'(T0_OFFSET) - coeffs[COEF_W*j +: 13];
    end
  end

endmodule

// File: rtl/pack_sk_seq.sv
// pack_sk_seq: sequential Dilithium3 secret-key packer. Writes the 4032-byte
// sk as 1008 words: a 32-word header {tr, key, rho}, then 5 s1, 6 s2 and
// 6 t0 polynomials fetched one at a time and packed by a single shared eta
// packer and a single shared t0 packer.
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin packing (only looked at in IDLE)
//   rho_in/key_in/tr_in  seeds captured on accepted start
//   busy, done         status; done is a one-cycle pulse at the end
//   poly_req/poly_sel/poly_ack/poly_data  polynomial fetch handshake
//   sk_wr_en/addr/data/ready              sk word write port
module pack_sk_seq
  import pack_sk_seq_pkg::*;
#(
  parameter int K      = 6,
  parameter int L      = 5,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [255:0]      rho_in,
  input  logic [255:0]      key_in,
  input  logic [511:0]      tr_in,
  output logic              busy,
  output logic              done,
  output logic              poly_req,
  output logic [4:0]        poly_sel,
  input  logic              poly_ack,
  input  logic [POLY_W-1:0] poly_data,
  output logic              sk_wr_en,
  output logic [9:0]        sk_wr_addr,
  output logic [WORD_W-1:0] sk_wr_data,
  input  logic              sk_wr_ready
);

  localparam logic [4:0] LAST_IDX = 5'(L + 2 * K - 1);

  state_t              state, state_nxt;
  logic [4:0]          poly_idx, poly_idx_nxt;
  logic                emit_load, emit_arm, emit_active, last_xfer;
  logic [T0_BITS-1:0]  load_data;
  logic [9:0]          arm_base;
  logic [6:0]          arm_words;
  logic [ETA_BITS-1:0] eta_packed;
  logic [T0_BITS-1:0]  t0_packed;

  polyeta_pack u_eta (.coeffs(poly_data), .packed_out(eta_packed));
  polyt0_pack  u_t0  (.coeffs(poly_data), .packed_out(t0_packed));

  // The emitter's pack register doubles as the header register: the header
  // is loaded there on start and drained during HDR.
  sk_word_emitter u_emit (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (emit_load),
    .load_data (load_data),
    .arm       (emit_arm),
    .base_in   (arm_base),
    .nwords_in (arm_words),
    .active    (emit_active),
    .wr_ready  (sk_wr_ready),
    .wr_en     (sk_wr_en),
    .wr_addr   (sk_wr_addr),
    .wr_data   (sk_wr_data),
    .last_xfer (last_xfer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      poly_idx <= '0;
    end else begin
      state    <= state_nxt;
      poly_idx <= poly_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    poly_idx_nxt = poly_idx;
    emit_load    = 1'b0;
    emit_arm     = 1'b0;
    emit_active  = 1'b0;
    load_data    = '0;
    arm_base     = '0;
    arm_words    = '0;
    busy         = 1'b1;
    done         = 1'b0;
    poly_req     = 1'b0;
    poly_sel     = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt    = HDR;
          poly_idx_nxt = '0;
          emit_load    = 1'b1;
          emit_arm     = 1'b1;
          load_data    = {{(T0_BITS - HDR_BITS){1'b0}}, tr_in, key_in, rho_in};
          arm_words    = 7'(HDR_WORDS);
        end
      end
      HDR: begin
        emit_active = 1'b1;
        if (last_xfer) begin
          state_nxt    = REQ;
          poly_idx_nxt = '0;
        end
      end
      REQ: begin
        poly_req = 1'b1;
        poly_sel = poly_idx;
        if (poly_ack) begin
          emit_load = 1'b1;
          load_data = (poly_idx < 5'(T0_SEL_FIRST)) ?
                      {{(T0_BITS - ETA_BITS){1'b0}}, eta_packed} : t0_packed;
          state_nxt = PACK;
        end
      end
      // Bubble cycle: base address and length are registered here so the
      // index-to-address arithmetic is off the write-port path.
      PACK: begin
        emit_arm  = 1'b1;
        arm_base  = poly_base(poly_idx);
        arm_words = poly_words(poly_idx);
        state_nxt = EMIT;
      end
      EMIT: begin
        emit_active = 1'b1;
        if (last_xfer) begin
          if (poly_idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            poly_idx_nxt = poly_idx + 5'd1;
            state_nxt    = REQ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pack_sk_seq.sv
// Self-checking bench for pack_sk_seq. A byte-level reference model of the
// Dilithium3 sk encoding builds the expected 1008 words, which are queued
// when a run is started; an independent monitor pops and compares on every
// write-port transfer and also watches stalls, poly_sel and done timing.
module tb_pack_sk_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] rho_in = '0;
  logic [255:0] key_in = '0;
  logic [511:0] tr_in = '0;
  logic         busy, done, poly_req;
  logic [4:0]   poly_sel;
  logic         poly_ack = 1'b0;
  logic [8191:0] poly_data = '0;
  logic         sk_wr_en;
  logic [9:0]   sk_wr_addr;
  logic [31:0]  sk_wr_data;
  logic         sk_wr_ready = 1'b0;

  pack_sk_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rho_in      (rho_in),
    .key_in      (key_in),
    .tr_in       (tr_in),
    .busy        (busy),
    .done        (done),
    .poly_req    (poly_req),
    .poly_sel    (poly_sel),
    .poly_ack    (poly_ack),
    .poly_data   (poly_data),
    .sk_wr_en    (sk_wr_en),
    .sk_wr_addr  (sk_wr_addr),
    .sk_wr_data  (sk_wr_data),
    .sk_wr_ready (sk_wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t          sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           coefs[17][256];
  byte unsigned exp_bytes[4032];
  bit           ready_rand = 0, ack_rand = 0, spurious_ack = 0, timing_check = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: sk = rho || key || tr || s1 || s2 || t0 as bytes, with
  // the eta and t0 byte formulas of the C reference implementation.
  task automatic build_sk(input bit const_golden);
    byte unsigned pat[13] = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h40, 8'h00, 8'h08,
                              8'h00, 8'h01, 8'h20, 8'h00, 8'h04, 8'h80};
    int unsigned t[8];
    int base;
    for (int b = 0; b < 32; b++) exp_bytes[b] = rho_in[8*b +: 8];
    for (int b = 0; b < 32; b++) exp_bytes[32+b] = key_in[8*b +: 8];
    for (int b = 0; b < 64; b++) exp_bytes[64+b] = tr_in[8*b +: 8];
    for (int p = 0; p < 11; p++) begin
      for (int b = 0; b < 128; b++) begin
        int t0, t1;
        t0 = 4 - coefs[p][2*b];
        t1 = 4 - coefs[p][2*b+1];
        exp_bytes[128 + 128*p + b] = const_golden ? 8'h00 : 8'(t0 | (t1 << 4));
      end
    end
    for (int q = 0; q < 6; q++) begin
      for (int i = 0; i < 32; i++) begin
        base = 1536 + 416*q + 13*i;
        if (const_golden) begin
          for (int k = 0; k < 13; k++) exp_bytes[base+k] = pat[k];
        end else begin
          for (int k = 0; k < 8; k++) t[k] = 32'(4096 - coefs[11+q][8*i+k]);
          exp_bytes[base+0]  = 8'(t[0]);
          exp_bytes[base+1]  = 8'((t[0] >> 8) | (t[1] << 5));
          exp_bytes[base+2]  = 8'(t[1] >> 3);
          exp_bytes[base+3]  = 8'((t[1] >> 11) | (t[2] << 2));
          exp_bytes[base+4]  = 8'((t[2] >> 6) | (t[3] << 7));
          exp_bytes[base+5]  = 8'(t[3] >> 1);
          exp_bytes[base+6]  = 8'((t[3] >> 9) | (t[4] << 4));
          exp_bytes[base+7]  = 8'(t[4] >> 4);
          exp_bytes[base+8]  = 8'((t[4] >> 12) | (t[5] << 1));
          exp_bytes[base+9]  = 8'((t[5] >> 7) | (t[6] << 6));
          exp_bytes[base+10] = 8'(t[6] >> 2);
          exp_bytes[base+11] = 8'((t[6] >> 10) | (t[7] << 3));
          exp_bytes[base+12] = 8'(t[7] >> 5);
        end
      end
    end
    for (int w = 0; w < 1008; w++) begin
      wr_t e;
      e.addr = 10'(w);
      e.data = {exp_bytes[4*w+3], exp_bytes[4*w+2], exp_bytes[4*w+1], exp_bytes[4*w]};
      sb.push_back(e);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) rho_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) key_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) tr_in[32*i +: 32] = $urandom;
    for (int p = 0; p < 17; p++)
      for (int j = 0; j < 256; j++)
        coefs[p][j] = (p < 11) ? int'($urandom_range(0, 8)) - 4
                               : int'($urandom_range(0, 8191)) - 4095;
  endtask

  // Starts a run (caller guarantees IDLE, time = posedge+1) and follows it
  // to the IDLE cycle after DONE. spam drives start randomly while busy and
  // high in the DONE cycle; hold_next leaves start high on return.
  task automatic applyStimulus(input bit const_golden, input bit spam, input bit hold_next);
    bit finished = 0;
    bit done_seen = 0;
    build_sk(const_golden);
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_rise", busy, 1);
    start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int c = 0; c < 30000 && !finished; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_seen = 1;
        start = spam;
      end else if (done_seen) begin
        start = hold_next;
        finished = 1;
      end else begin
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (!finished) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL run_timeout: got no done, required done within 30000 cycles");
      start = 1'b0;
    end
  endtask

  task automatic resetMidEmit();
    int c = 0;
    fill_random();
    build_sk(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(poly_req && poly_sel == 5'd7) && c < 20000) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 20000) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL poly7_timeout: got no request, required poly 7 request");
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("pre_reset_en", sk_wr_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req", poly_req, 0);
    checkOutput("rst_sel", poly_sel, 0);
    checkOutput("rst_en", sk_wr_en, 0);
    checkOutput("rst_addr", sk_wr_addr, 0);
    checkOutput("rst_data", sk_wr_data, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Sink and coefficient-memory responder, driven just after each edge.
  initial begin : responder
    int wait_cnt = -1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        poly_ack = 1'b0;
        sk_wr_ready = 1'b0;
        wait_cnt = -1;
      end else begin
        sk_wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        poly_ack = 1'b0;
        if (poly_req) begin
          if (wait_cnt < 0) wait_cnt = ack_rand ? int'($urandom_range(0, 5)) : 0;
          if (wait_cnt == 0) begin
            for (int j = 0; j < 256; j++) poly_data[32*j +: 32] = coefs[poly_sel][j];
            poly_ack = 1'b1;
            wait_cnt = -1;
          end else begin
            poly_data = {256{$urandom}};
            wait_cnt--;
          end
        end else if (spurious_ack && $urandom_range(0, 3) == 0) begin
          poly_data = {256{$urandom}};
          poly_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks stall stability,
  // poly_sel order/stability and the conditions around done.
  bit         prev_stall = 0, prev_wait = 0, prev_done = 0, prev_busy = 0;
  logic [9:0] stall_addr;
  logic [31:0] stall_data;
  logic [4:0] wait_sel;
  int         since = 0, xfers = 0, exp_sel = 0;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!rst_n) begin
      prev_stall = 0; prev_wait = 0; prev_done = 0; prev_busy = 0;
      since = 0; xfers = 0; exp_sel = 0;
    end else begin
      if (busy && !prev_busy) begin
        since = 1; xfers = 0; exp_sel = 0;
      end else if (busy) begin
        since++;
      end
      if (prev_done) checkOutput("busy_after_done", busy, 0);
      if (prev_stall) begin
        checkOutput("stall_en", sk_wr_en, 1);
        checkOutput("stall_addr", sk_wr_addr, stall_addr);
        checkOutput("stall_data", sk_wr_data, stall_data);
      end
      prev_stall = sk_wr_en && !sk_wr_ready;
      stall_addr = sk_wr_addr;
      stall_data = sk_wr_data;
      if (prev_wait) begin
        checkOutput("sel_hold_req", poly_req, 1);
        checkOutput("sel_hold", poly_sel, wait_sel);
      end
      prev_wait = poly_req && !poly_ack;
      wait_sel = poly_sel;
      if (poly_req && poly_ack) begin
        checkOutput("poly_sel", poly_sel, 64'(exp_sel));
        exp_sel++;
      end
      if (sk_wr_en && sk_wr_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("[TB] FAIL wr_unexpected: got write addr 0x%0h, required no write", sk_wr_addr);
        end else begin
          e = sb.pop_front();
          checkOutput("wr_addr", sk_wr_addr, e.addr);
          checkOutput("wr_data", sk_wr_data, e.data);
        end
      end
      if (done) begin
        checkOutput("xfer_count", xfers, 1008);
        checkOutput("sb_empty", sb.size(), 0);
        if (timing_check) checkOutput("done_cycle", since, 1043);
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_en", sk_wr_en, 0);
    checkOutput("reset_req", poly_req, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_addr", sk_wr_addr, 0);

    $display("[TB] directed header, ready and ack tied high");
    fill_random();
    for (int i = 0; i < 32; i++) rho_in[8*i +: 8] = 8'(i + 1);
    for (int i = 0; i < 32; i++) key_in[8*i +: 8] = 8'(i + 33);
    for (int i = 0; i < 64; i++) tr_in[8*i +: 8] = 8'(i + 65);
    timing_check = 1;
    applyStimulus(0, 0, 0);

    $display("[TB] constant coefficients, golden t0 pattern");
    for (int p = 0; p < 17; p++)
      for (int j = 0; j < 256; j++) coefs[p][j] = (p < 11) ? 4 : 0;
    applyStimulus(1, 0, 0);
    timing_check = 0;

    $display("[TB] random coefficients, random ack delay");
    fill_random();
    ack_rand = 1; spurious_ack = 1;
    applyStimulus(0, 0, 0);

    $display("[TB] random ready, start spammed while busy");
    fill_random();
    ready_rand = 1;
    applyStimulus(0, 1, 0);

    $display("[TB] reset during poly 7, then fresh run");
    ready_rand = 0; ack_rand = 0; spurious_ack = 0;
    resetMidEmit();
    fill_random();
    applyStimulus(0, 0, 0);

    $display("[TB] start held through DONE into IDLE");
    fill_random();
    ack_rand = 1;
    applyStimulus(0, 1, 1);
    fill_random();
    applyStimulus(0, 0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pack_sk_seq.md
Name: pack_sk_seq

Overview:
- Sequential secret-key packer for the Dilithium3 parameter set (K=6, L=5, ETA=4).
- Streams the 4032-byte packed sk out as 32-bit words through a write port.
- Polynomials are fetched one at a time from the coefficient-memory side over a req/ack handshake.
- One shared eta packer and one shared t0 packer are time-multiplexed over all 17 polynomials (5×s1, 6×s2, 6×t0), instead of 17 parallel packer instances.

Parameters:
- K, 6, number of s2/t0 polynomials
- L, 5, number of s1 polynomials
- WORD_W, 32, output word width in bits; only 32 is supported

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin packing; sampled only in IDLE
- rho_in  input  256  seed rho; captured on accepted start
- key_in  input  256  key; captured on accepted start
- tr_in  input  512  tr; captured on accepted start
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse after the last word transfer
- poly_req  output  1  polynomial fetch request
- poly_sel  output  5  polynomial index: 0..4 = s1[i], 5..10 = s2[i], 11..16 = t0[i]
- poly_ack  input  1  poly_data valid; may be asserted in the same cycle as poly_req
- poly_data  input  8192  256 coefficients × 32 bit, coefficient j at [32j+31:32j]
- sk_wr_en  output  1  word valid
- sk_wr_addr  output  10  word address, 0..1007
- sk_wr_data  output  32  sk bits [32·addr+31 : 32·addr]
- sk_wr_ready  input  1  sink accepts the word

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters and header/pack registers cleared. Reset asserted mid-operation aborts immediately; no resume.
- FSM states: IDLE, HDR, REQ, PACK, EMIT, DONE.
- IDLE: if start=1, capture rho/key/tr into a 1024-bit header register (layout {tr, key, rho}, rho at LSB), set word_cnt=0, go to HDR. start seen while busy is ignored.
- HDR: sk_wr_en=1; word w is header bits [32w+31:32w] at addr w. On each transfer (wr_en && ready) advance. After word 31 transfers, set poly_idx=0 and go to REQ.
- REQ: poly_req=1, poly_sel=poly_idx, both held stable until poly_ack=1. On the ack cycle, latch the packed result of poly_data into a 3328-bit pack register, then go to PACK.
  - poly_idx < 11: polyeta_pack output, 1024 bits, 32 words.
  - poly_idx ≥ 11: polyt0_pack output, 3328 bits, 104 words.
  - poly_ack while poly_req=0 is ignored.
- PACK: one bubble cycle; register the poly base address and word count. Go to EMIT.
- Base addresses:
  - s1[i]: 32 + 32i
  - s2[i]: 192 + 32i
  - t0[i]: 384 + 104i
- EMIT: sk_wr_en=1, addr = base + n, data = pack_reg[32n+31:32n]. addr and data must stay stable while ready=0. After the last word transfers:
  - poly_idx < 16: poly_idx+1, go to REQ.
  - poly_idx = 16: go to DONE.
- DONE: done=1 for one cycle, busy still 1; next state IDLE with busy=0.
- Address rules: addresses are strictly increasing and never wrap; 1008 transfers in total, each address exactly once.
- Latency with ready and ack tied high: HDR 32 cycles + 11×(1+1+32) + 6×(1+1+104) = 1042 cycles. done is asserted 1043 cycles after the start-accept edge.
- Back-to-back operation: start held high during the DONE cycle is not accepted; it is accepted in the following IDLE cycle.

Decomposition:
- Shared package holds: K, L, SK_WORDS=1008, HDR_WORDS=32, ETA_WORDS=32, T0_WORDS=104, S1_BASE=32, S2_BASE=192, T0_BASE=384, T0_SEL_FIRST=11, and the state enum.
- The existing polyeta_pack and polyt0_pack are instantiated once each, feeding a mux.
- One sub-module, sk_word_emitter: pack register, word counter and write-port stall logic. It is reused by both the HDR and EMIT states.

Test Plan:
- rho=0x01..20 bytes, key=0x21..40 bytes, tr=0x41..80 bytes, ready=1, ack same cycle as req:
  - words 0..31 match the header;
  - done pulses at cycle 1043;
  - addresses run 0..1007 with no gaps.
- All s1/s2 coefficients = 4 (η−c = 0), all t0 coefficients = 0 (2^12 − 0 = 0x1000 per 13-bit field):
  - words 32..383 are all 0;
  - words 384..1007 match the golden 13-bit packing of 0x1000 from the C reference implementation.
- Random coefficients, ack delayed 0–5 random cycles:
  - output matches the combinational sk packing golden model bit-for-bit;
  - poly_sel stays stable during every wait.
- sk_wr_ready toggled randomly at 50%:
  - exactly 1008 transfers;
  - addr/data unchanged across every stall cycle;
  - done only after transfer 1008.
- rst_n pulsed low during EMIT of poly 7:
  - all outputs 0 at once, FSM in IDLE;
  - a fresh start produces a complete, correct sk from address 0.
- start re-asserted while busy, and during the DONE cycle:
  - ignored in both cases;
  - the following IDLE-cycle start is accepted and busy rises the cycle after.
